// File: rtl/fade_arb.sv
// -----------------------------------------------------------------------------
// fade_arb
//
// Shares a single duty-ramp fade engine among N_CH LED channels. Channels
// request with a level on req; a registered round-robin decision picks one
// owner, launches the engine with a one-clock eng_start pulse, routes a PWM
// waveform built from the engine's live duty value to the owner, and returns
// a one-clock done pulse when the engine reports eng_ready.
//
// Sequence per fade: IDLE -> LAUNCH -> RUN -> DONE -> GAP -> IDLE.
// The GAP clock keeps eng_start low for at least two clocks before the next
// rising edge, so the edge-triggered engine always sees a clean restart.
//
// Optional build macro:
//   FADE_TIMEOUT_EN  - adds a RUN watchdog of TO_CYCLES clocks. On expiry the
//                      fade is aborted: done[owner] and err pulse together.
//                      Without the macro err is tied low and RUN waits forever.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   req        in   [N_CH] per-channel fade request (level, hold until done)
//   grant      out  [N_CH] one-hot engine owner, 0 when idle
//   done       out  [N_CH] one-clock completion pulse to the owner
//   busy       out  engine owned (state != IDLE)
//   eng_start  out  launch pulse to the fade engine (rising-edge triggered)
//   eng_duty   in   [4] engine's current duty value, 0..PWM_PERIOD
//   eng_ready  in   engine completion pulse (honoured only in RUN)
//   pwm_out    out  [N_CH] PWM per channel, only the owner toggles
//   err        out  one-clock pulse on watchdog abort
// -----------------------------------------------------------------------------
module fade_arb #(
  parameter int N_CH       = 4,
  parameter int PWM_PERIOD = 10,
  parameter int TO_CYCLES  = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic [N_CH-1:0] done,
  output logic            busy,
  output logic            eng_start,
  input  logic [3:0]      eng_duty,
  input  logic            eng_ready,
  output logic [N_CH-1:0] pwm_out,
  output logic            err
);

  localparam int PW = $clog2(N_CH);
  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE,
    GAP
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [N_CH-1:0] grant_q;
  logic [N_CH-1:0] done_q;
  logic            busy_q;
  logic            eng_start_q;
  logic [CW-1:0]   pwm_cnt_q;
  logic [N_CH-1:0] pwm_out_q;

  // ---------------------------------------------------------------------------
  // Round-robin pick. The request vector is rotated so that bit 0 is the
  // channel at rr_ptr; the lowest set bit of the rotated vector is the winner.
  // ---------------------------------------------------------------------------
  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic              any_req;
  logic [PW:0]       win_sum;
  logic [PW-1:0]     win_idx;
  logic [N_CH-1:0]   grant_d;
  logic [PW-1:0]     rr_ptr_d;

  assign req_dbl = {req, req};
  assign req_rot = N_CH'(req_dbl >> rr_ptr_q);
  assign any_req = |req;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it holding a value and infer a latch.
  always_comb begin
    win_sum = '0;
    win_idx = '0;
    // Scan from the far end so the lowest rotated index is the last writer.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
        if (win_sum >= (PW+1)'(N_CH)) begin
          win_sum = win_sum - (PW+1)'(N_CH);
        end
        win_idx = win_sum[PW-1:0];
      end
    end
  end

  // The channel that just won becomes the lowest priority next round.
  assign grant_d  = N_CH'(1) << win_idx;
  assign rr_ptr_d = (win_idx == PW'(N_CH - 1)) ? '0 : win_idx + PW'(1);

`ifdef FADE_TIMEOUT_EN
  localparam int WW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [WW-1:0] wd_cnt_q;
  logic          err_q;
`else
  // Watchdog limit has no meaning in this build.
  logic unused_to;
  assign unused_to = (TO_CYCLES > 0);
`endif

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs are registered and change with the state.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
`ifdef FADE_TIMEOUT_EN
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            state_q  <= LAUNCH;
          end
        end

        LAUNCH: begin
          eng_start_q <= 1'b1;
`ifdef FADE_TIMEOUT_EN
          wd_cnt_q    <= '0;
`endif
          state_q     <= RUN;
        end

        RUN: begin
          // A dropped req does not abort: the engine is already ramping.
          eng_start_q <= 1'b0;
          if (eng_ready) begin
            done_q  <= grant_q;
            state_q <= DONE;
          end
`ifdef FADE_TIMEOUT_EN
          else if (wd_cnt_q == WW'(TO_CYCLES - 1)) begin
            done_q  <= grant_q;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            wd_cnt_q <= wd_cnt_q + WW'(1);
          end
`endif
        end

        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
`ifdef FADE_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= GAP;
        end

        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PWM. Free-running frame counter; the owner is high while the counter is
  // below the engine's duty, so duty 0 is always off and duty >= PWM_PERIOD
  // is always on.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] pwm_cnt_d;
  logic          pwm_on;

  assign pwm_cnt_d = (pwm_cnt_q == CW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + CW'(1);
  assign pwm_on    = (int'(pwm_cnt_q) < int'(eng_duty));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= '0;
      pwm_out_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= grant_q & {N_CH{pwm_on}};
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign pwm_out   = pwm_out_q;
`ifdef FADE_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fade_arb.sv
// -----------------------------------------------------------------------------
// tb_fade_arb
//
// Self-checking bench for fade_arb (N_CH=4, PWM_PERIOD=10, TO_CYCLES=50).
// A table of single-fade records drives request/duty patterns and states the
// expected winner and PWM high time per frame; hand-written sequences cover
// held round-robin, request drop mid-fade, asynchronous reset mid-fade and,
// when FADE_TIMEOUT_EN is defined, the watchdog abort. A monitor pops the
// expected grant/done owners from queues filled when stimulus is applied.
// -----------------------------------------------------------------------------
module tb_fade_arb;

  localparam int N_CH       = 4;
  localparam int PWM_PERIOD = 10;
  localparam int TO_CYCLES  = 50;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic [3:0] req       = '0;
  logic [3:0] eng_duty  = '0;
  logic       eng_ready = 1'b0;
  logic [3:0] grant;
  logic [3:0] done;
  logic [3:0] pwm_out;
  logic       busy;
  logic       eng_start;
  logic       err;

  fade_arb #(
    .N_CH      (N_CH),
    .PWM_PERIOD(PWM_PERIOD),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .eng_start(eng_start),
    .eng_duty (eng_duty),
    .eng_ready(eng_ready),
    .pwm_out  (pwm_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Sample point for the main thread: just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  logic [3:0] exp_grant_q[$];
  logic [3:0] exp_done_q[$];
  logic       exp_err    = 1'b0;
  logic [3:0] prev_grant = '0;

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      prev_grant = '0;
    end else begin
      if (grant != '0 && prev_grant == '0) begin
        if (exp_grant_q.size() == 0) check("sb_grant_unexpected", grant, 0);
        else                          check("sb_grant", grant, exp_grant_q.pop_front());
      end
      if (done != '0) begin
        if (exp_done_q.size() == 0) check("sb_done_unexpected", done, 0);
        else                         check("sb_done", done, exp_done_q.pop_front());
        check("sb_err_with_done", err, exp_err);
      end else if (err) begin
        check("sb_err_alone", err, 0);
      end
      prev_grant = grant;
    end
  end

  // ---------------------------------------------------------------------------
  // Table-driven single fades
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] duty;
    int         ready_delay;
    logic [3:0] exp_grant;
    int         exp_high;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    int         hi;
    logic [3:0] others;
    hi     = 0;
    others = '0;
    exp_grant_q.push_back(v.exp_grant);
    exp_done_q.push_back(v.exp_grant);
    req      = v.req;
    eng_duty = v.duty;
    tick();
    check("vec_grant_latency", grant, v.exp_grant);
    check("vec_start_low_at_grant", eng_start, 0);
    tick();
    check("vec_start_pulse", eng_start, 1);
    tick();
    check("vec_start_one_clock", eng_start, 0);
    for (int i = 0; i < PWM_PERIOD; i++) begin
      if ((pwm_out & v.exp_grant) != '0) hi++;
      others = others | (pwm_out & ~v.exp_grant);
      tick();
    end
    check("vec_pwm_high_count", hi, v.exp_high);
    check("vec_pwm_others_zero", others, 0);
    repeat (v.ready_delay) tick();
    check("vec_busy_in_run", busy, 1);
    pulse_ready();
    check("vec_done_pulse", done, v.exp_grant);
    req = '0;
    tick();
    check("vec_done_one_clock", done, 0);
    check("vec_grant_cleared", grant, 0);
    check("vec_busy_in_gap", busy, 1);
    tick();
    check("vec_busy_idle", busy, 0);
  endtask

  logic [3:0] rr_exp [5];
  int         last_start;
  int         n;
  int         t0;

  initial begin
    // Round-robin pointer starts at 0 and moves to winner+1 after each grant.
    vecs[0] = '{4'b0001, 4'd0,  200, 4'b0001, 0};   // ptr -> 1
    vecs[1] = '{4'b0100, 4'd3,  4,   4'b0100, 3};   // ptr -> 3
    vecs[2] = '{4'b0101, 4'd10, 2,   4'b0001, 10};  // wraps 3 -> 0, ptr -> 1
    vecs[3] = '{4'b0101, 4'd5,  0,   4'b0100, 5};   // ptr -> 3
    vecs[4] = '{4'b1010, 4'd15, 3,   4'b1000, 10};  // duty above period, ptr -> 0
    vecs[5] = '{4'b1010, 4'd7,  1,   4'b0010, 7};   // ptr -> 2
    vecs[6] = '{4'b1111, 4'd1,  2,   4'b0100, 1};   // ptr -> 3
    vecs[7] = '{4'b1001, 4'd9,  5,   4'b1000, 9};   // ptr -> 0
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();

    // eng_ready while idle is ignored
    pulse_ready();
    check("idle_ready_no_done", done, 0);
    check("idle_ready_not_busy", busy, 0);
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Held requests rotate 0,1,2,3,0 with spaced launches
    req = 4'hF;
    foreach (rr_exp[i]) begin
      exp_grant_q.push_back(rr_exp[i]);
      exp_done_q.push_back(rr_exp[i]);
    end
    last_start = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (eng_start !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      check("rr_start_seen", eng_start, 1);
      if (k > 0) check("rr_start_gap_ge3", (cyc - last_start) >= 3, 1);
      check("rr_grant", grant, rr_exp[k]);
      last_start = cyc;
      repeat (2) tick();
      if (k == 4) req = '0;
      pulse_ready();
      check("rr_done", done, rr_exp[k]);
      tick();
    end
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    check("rr_idle_after", busy, 0);

    // Request dropped mid-fade: fade completes, no re-grant
    req = 4'b0010;                                   // ptr 1 -> ch1, ptr -> 2
    exp_grant_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    tick();
    check("drop_grant", grant, 4'b0010);
    repeat (3) tick();
    req = '0;
    repeat (5) tick();
    check("drop_still_busy", busy, 1);
    check("drop_still_granted", grant, 4'b0010);
    pulse_ready();
    check("drop_done", done, 4'b0010);
    repeat (8) tick();
    check("drop_no_regrant", grant, 0);
    check("drop_idle", busy, 0);

    // Asynchronous reset mid-fade
    req      = 4'b0010;                              // ptr 2 -> ch1, ptr -> 2
    eng_duty = 4'd10;
    exp_grant_q.push_back(4'b0010);
    tick();
    check("arst_pre_grant", grant, 4'b0010);
    tick();
    check("arst_pre_start", eng_start, 1);
    check("arst_pre_pwm", pwm_out, 4'b0010);
    #2;
    rst = 1'b0;
    req = 4'b0110;
    #1;
    check("arst_grant", grant, 0);
    check("arst_pwm_out", pwm_out, 0);
    check("arst_busy", busy, 0);
    check("arst_eng_start", eng_start, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    repeat (2) @(posedge clk);
    #3;
    check("arst_hold_grant", grant, 0);
    // Pointer back at 0 picks ch1 ahead of ch2.
    exp_grant_q.push_back(4'b0010);
    exp_done_q.push_back(4'b0010);
    rst = 1'b1;
    tick();
    check("arst_rr_from_zero", grant, 4'b0010);
    repeat (3) tick();
    pulse_ready();
    check("arst_done_after", done, 4'b0010);
    req = '0;
    repeat (3) tick();
    check("arst_idle_after", busy, 0);

`ifdef FADE_TIMEOUT_EN
    // Engine never readies: abort TO_CYCLES clocks after the start pulse
    req     = 4'b0001;                               // ptr 2 -> ch0
    exp_err = 1'b1;
    exp_grant_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    tick();
    check("to_grant", grant, 4'b0001);
    tick();
    check("to_start", eng_start, 1);
    t0 = cyc;
    n  = 0;
    while (done == '0 && n < TO_CYCLES + 20) begin
      tick();
      n++;
    end
    check("to_latency", cyc - t0, TO_CYCLES);
    check("to_done", done, 4'b0001);
    check("to_err", err, 1);
    req = '0;
    tick();
    exp_err = 1'b0;
    check("to_err_one_clock", err, 0);
    pulse_ready();
    check("to_late_ready_no_done", done, 0);
    tick();
    check("to_idle", busy, 0);
`endif

    repeat (5) tick();
    check("sb_grant_drained", exp_grant_q.size(), 0);
    check("sb_done_drained", exp_done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "global timeout");
  end

endmodule
